noc_output_arbiter: RTL and testbench

//  Round-robin, wormhole-locking arbiter sharing one router output channel among NUM_IN input ports.

---
 rtl/noc_output_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_noc_output_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Round-robin, wormhole-locking output arbiter: grants one packet at a time per output
// channel, gated on downstream credits. Define NOC_ARB_TIMEOUT_EN to add a lock watchdog.
module noc_output_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 68,
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 255,
  localparam int PTR_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req_valid,
  input  logic [NUM_IN*FLIT_W-1:0] req_flit,
  output logic [NUM_IN-1:0]        req_ready,
  input  logic                     credit_in,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  output logic [PTR_W-1:0]         grant_id,
  output logic                     locked,
  output logic                     error
);

  localparam int CRED_W = $clog2(CREDITS + 1);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic                error_q, error_d;
  logic                out_valid_q;
  logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
  logic [PTR_W-1:0]    grant_id_q, grant_id_d;

  logic [FLIT_W-1:0]   flits [NUM_IN];
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic                xfer;
  logic                win_head;
  logic                win_tail;

`ifdef NOC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign flits[g] = req_flit[g*FLIT_W +: FLIT_W];
  end

  // Circular increment that also works for non-power-of-two NUM_IN.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return PTR_W'(s);
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      credits_q   <= CRED_W'(CREDITS);
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
      // NOTE: the flit datapath register is reset too, because out_flit must read zero after reset.
      out_flit_q  <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      credits_q   <= credits_d;
      error_q     <= error_d;
      out_valid_q <= xfer;
      out_flit_q  <= out_flit_d;
      grant_id_q  <= grant_id_d;
    end
  end

`ifdef NOC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  // Arbitration and next-state logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    win_found  = 1'b0;
    win_idx    = '0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    credits_d  = credits_q;
    error_d    = error_q;
    out_flit_d = out_flit_q;
    grant_id_d = grant_id_q;
`ifdef NOC_ARB_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    if (state_q == S_IDLE) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!win_found && req_valid[ptr_add(rr_ptr_q, k)] && flits[ptr_add(rr_ptr_q, k)][0]) begin
          win_found = 1'b1;
          win_idx   = ptr_add(rr_ptr_q, k);
        end
      end
    end else begin
      win_found = req_valid[owner_q];
      win_idx   = owner_q;
    end

    xfer     = win_found && (credits_q != '0);
    win_head = flits[win_idx][0];
    win_tail = flits[win_idx][1];

    if (xfer) begin
      out_flit_d = flits[win_idx];
      grant_id_d = win_idx;
      if (state_q == S_IDLE) begin
        if (win_tail) begin
          rr_ptr_d = ptr_add(win_idx, 1);
        end else begin
          state_d = S_LOCKED;
          owner_d = win_idx;
        end
      end else begin
        // A head inside an open packet is a protocol error; it still travels as body.
        if (win_head) error_d = 1'b1;
        if (win_tail) begin
          state_d  = S_IDLE;
          rr_ptr_d = ptr_add(owner_q, 1);
        end
      end
    end

    unique case ({xfer, credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_W'(CREDITS)) error_d = 1'b1;
        else                               credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase

`ifdef NOC_ARB_TIMEOUT_EN
    if (state_q == S_LOCKED && !xfer) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        error_d  = 1'b1;
        state_d  = S_IDLE;
        rr_ptr_d = ptr_add(owner_q, 1);
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  // Outputs.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win_idx] = 1'b1;
    locked    = (state_q == S_LOCKED);
    out_valid = out_valid_q;
    out_flit  = out_flit_q;
    grant_id  = grant_id_q;
    error     = error_q;
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a packet-level reference model.
module tb_noc_output_arbiter;

  localparam int N  = 4;
  localparam int W  = 68;
  localparam int CR = 4;
  localparam int TO = 8;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_flit;
  logic [N-1:0]       req_ready;
  logic               credit_in;
  logic               out_valid;
  logic [W-1:0]       out_flit;
  logic [1:0]         grant_id;
  logic               locked;
  logic               error;

  noc_output_arbiter #(
    .NUM_IN (N),
    .FLIT_W (W),
    .CREDITS(CR),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_flit (req_flit),
    .req_ready(req_ready),
    .credit_in(credit_in),
    .out_valid(out_valid),
    .out_flit (out_flit),
    .grant_id (grant_id),
    .locked   (locked),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: packet-level view of the channel.
  bit         m_locked;
  int         m_owner;
  int         m_ptr;
  int         m_cred;
  bit         m_err;
  bit         m_ov;
  logic [W-1:0] m_of;
  int         m_gid;
  int         m_idle;
  int         m_win;

  logic [W-1:0] f [N];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit head, input bit tail);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {r[W-3:0], tail, head};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CR; m_err = 0;
    m_ov = 0; m_of = '0; m_gid = 0; m_idle = 0;
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    credit_in = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_locked", locked, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_error", error, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive at negedge, check ready, clock, check registered outputs.
  task automatic step(input logic [N-1:0] v, input bit ci);
    req_valid = v;
    credit_in = ci;
    for (int i = 0; i < N; i++) req_flit[i*W +: W] = f[i];
    #1;
    m_win = -1;
    if (m_cred > 0) begin
      if (m_locked) begin
        if (v[m_owner]) m_win = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int p = (m_ptr + k) % N;
          if (m_win < 0 && v[p] && f[p][0]) m_win = p;
        end
      end
    end
    check("req_ready", req_ready, (m_win >= 0) ? (1 << m_win) : 0);
    @(posedge clk);
    if (m_win >= 0) begin
      m_ov = 1; m_of = f[m_win]; m_gid = m_win; m_idle = 0;
      if (m_locked) begin
        if (f[m_win][0]) m_err = 1;
        if (f[m_win][1]) begin m_locked = 0; m_ptr = (m_win + 1) % N; end
      end else if (f[m_win][1]) begin
        m_ptr = (m_win + 1) % N;
      end else begin
        m_locked = 1; m_owner = m_win;
      end
    end else begin
      m_ov = 0;
`ifdef NOC_ARB_TIMEOUT_EN
      if (m_locked) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1; m_locked = 0; m_ptr = (m_owner + 1) % N; m_idle = 0;
        end
      end
`endif
    end
    if (m_win >= 0 && !ci) m_cred--;
    else if (m_win < 0 && ci) begin
      if (m_cred == CR) m_err = 1;
      else m_cred++;
    end
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_flit", out_flit, m_of);
    check("grant_id", grant_id, m_gid);
    check("locked", locked, m_locked);
    check("error", error, m_err);
    @(negedge clk);
  endtask

  task automatic all_single();
    for (int i = 0; i < N; i++) f[i] = mk(1, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = '0;
    credit_in = 1'b0;
    req_flit = '0;
    for (int i = 0; i < N; i++) f[i] = '0;
    do_reset();

    // 1: single-flit packets on all ports, credit exhaustion and refill.
    for (int g = 0; g < N; g++) begin
      all_single(); step(4'hF, 0);
      check("t1_grant", grant_id, g);
    end
    all_single(); step(4'hF, 0);
    check("t1_stall_valid", out_valid, 0);
    for (int c = 0; c < CR; c++) step(4'h0, 1);
    check("t1_no_error", error, 0);
    for (int g = 0; g < N; g++) begin
      all_single(); step(4'hF, 0);
      check("t1_regrant", grant_id, g);
    end

    // 2: 3-flit wormhole packet from port 2 while port 1 keeps offering heads.
    do_reset();
    f[1] = mk(1, 1); step(4'b0010, 0);
    check("t2_pre", grant_id, 1);
    f[1] = mk(1, 1); f[2] = mk(1, 0); f[3] = mk(1, 1); step(4'b1110, 1);
    check("t2_head", grant_id, 2); check("t2_lock1", locked, 1);
    f[1] = mk(1, 1); f[2] = mk(0, 0); f[3] = mk(1, 1); step(4'b1110, 1);
    check("t2_body", grant_id, 2); check("t2_lock2", locked, 1);
    f[1] = mk(1, 1); f[2] = mk(0, 1); f[3] = mk(1, 1); step(4'b1110, 1);
    check("t2_tail", grant_id, 2); check("t2_unlock", locked, 0);
    f[1] = mk(1, 1); f[3] = mk(1, 1); step(4'b1010, 1);
    check("t2_next3", grant_id, 3);
    f[1] = mk(1, 1); step(4'b0010, 1);
    check("t2_next1", grant_id, 1);

    // 3: transfer and credit return in the same cycle at credits=1.
    do_reset();
    for (int i = 0; i < 3; i++) begin all_single(); step(4'b0001, 0); end
    all_single(); step(4'b0001, 1);
    all_single(); step(4'b0001, 0);
    check("t3_regrant", out_valid, 1);
    all_single(); step(4'b0001, 0);
    check("t3_empty", out_valid, 0);
    check("t3_error", error, 0);

    // 4: credit overflow is sticky.
    do_reset();
    step(4'h0, 1);
    check("t4_error", error, 1);
    for (int i = 0; i < 5; i++) begin all_single(); step(4'hF, 0); end
    check("t4_sticky", error, 1);

    // 5: reset in the middle of a packet.
    do_reset();
    f[2] = mk(1, 0); step(4'b0100, 0);
    f[2] = mk(0, 0); step(4'b0000, 0);
    check("t5_locked", locked, 1);
    do_reset();
    all_single(); step(4'hF, 0);
    check("t5_restart", grant_id, 0);

`ifdef NOC_ARB_TIMEOUT_EN
    // 6: stalled owner is evicted by the watchdog.
    do_reset();
    f[1] = mk(1, 0); f[2] = mk(1, 1); step(4'b0010, 0);
    for (int i = 0; i < TO; i++) step(4'b0100, 0);
    check("t6_unlocked", locked, 0);
    check("t6_error", error, 1);
    f[2] = mk(1, 1); step(4'b0100, 0);
    check("t6_next", grant_id, 2);
`else
    // 6: without the watchdog a stalled owner keeps the lock.
    do_reset();
    f[1] = mk(1, 0); f[2] = mk(1, 1); step(4'b0010, 0);
    for (int i = 0; i < 3 * TO; i++) step(4'b0100, 0);
    check("t6_held", locked, 1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) f[i] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      step(N'($urandom), $urandom_range(0, 2) == 0);
      if (n == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
